// File: rtl/pll_lock_supervisor.sv
// Pulses the PLL reset, waits for a stable synchronised lock, then releases staged domain resets in order.
// Any lock loss after release re-arms the whole sequence and bumps a saturating relock counter.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES   = 2,
    parameter int RESET_PULSE   = 16,
    parameter int LOCK_TIMEOUT  = 270000,
    parameter int STABLE_CYCLES = 1024,
    parameter int NUM_RST       = 3,
    parameter int STAGGER       = 256,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lock_i,
    output logic               pll_reset_o,
    output logic [NUM_RST-1:0] rst_out_o,
    output logic               locked_o,
    output logic               timeout_o,
    output logic [CNT_W-1:0]   relock_count_o
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CMP = max2(max2(RESET_PULSE - 1, LOCK_TIMEOUT - 1),
                                  max2(STABLE_CYCLES - 1, STAGGER - 1));
    localparam int CW      = (MAX_CMP < 1) ? 1 : $clog2(MAX_CMP + 1);
    localparam int IW      = (NUM_RST <= 2) ? 1 : $clog2(NUM_RST);

    localparam logic [CW-1:0] PULSE_LAST   = CW'(RESET_PULSE - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'((NUM_RST > 1) ? NUM_RST - 2 : 0);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          idx_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pll_reset_q;
    logic [NUM_RST-1:0]     rst_out_q;
    logic                   locked_q;
    logic                   timeout_q;
    logic [CNT_W-1:0]       relock_q;
    logic [CNT_W-1:0]       relock_d;
    logic                   lock_s;
    logic                   lost;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock_i};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        relock_d = (relock_q == '1) ? relock_q : relock_q + CNT_W'(1);
        lost     = !lock_s && (state_q == S_RELEASE || state_q == S_RUN);
    end

    // Released bits are shifted out from bit 0 upward, so they can only re-assert as a group.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            idx_q       <= '0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= '1;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
            relock_q    <= '0;
        end else if (lost) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            idx_q       <= '0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= '1;
            locked_q    <= 1'b0;
            relock_q    <= relock_d;
        end else begin
            case (state_q)
                S_PLL_RST: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_q     <= S_WAIT_LOCK;
                        cnt_q       <= '0;
                        pll_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q <= S_STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q     <= S_PLL_RST;
                        cnt_q       <= '0;
                        pll_reset_q <= 1'b1;
                        timeout_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        cnt_q     <= '0;
                        idx_q     <= '0;
                        rst_out_q <= rst_out_q << 1;
                        if (NUM_RST == 1) begin
                            state_q  <= S_RUN;
                            locked_q <= 1'b1;
                        end else begin
                            state_q <= S_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RELEASE: begin
                    if (cnt_q == STAGGER_LAST) begin
                        cnt_q     <= '0;
                        idx_q     <= idx_q + IW'(1);
                        rst_out_q <= rst_out_q << 1;
                        if (idx_q == IDX_LAST) begin
                            state_q  <= S_RUN;
                            locked_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RUN: begin
                    cnt_q <= '0;
                end
                default: begin
                    state_q     <= S_PLL_RST;
                    cnt_q       <= '0;
                    idx_q       <= '0;
                    pll_reset_q <= 1'b1;
                    rst_out_q   <= '1;
                    locked_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset_o    = pll_reset_q;
    assign rst_out_o      = rst_out_q;
    assign locked_o       = locked_q;
    assign timeout_o      = timeout_q;
    assign relock_count_o = relock_q;

endmodule
